// File: rtl/intra16_mode_decision_if.sv
// Request/result bundle between the macroblock extractor, the Intra16x16 mode decision block
// and the consumer of its result.
interface intra16_mode_decision_if;
  logic        start;
  logic [31:0] mbnumber;
  logic [7:0]  mb [256];
  logic        busy;
  logic        valid;
  logic        ack;
  logic [1:0]  best_mode;
  logic [15:0] best_sad;

  modport master (
    output start, mbnumber, mb, ack,
    input  busy, valid, best_mode, best_sad
  );

  modport slave (
    input  start, mbnumber, mb, ack,
    output busy, valid, best_mode, best_sad
  );
endinterface

// File: rtl/intra16_mode_decision.sv
// Intra16x16 mode decision: SAD of vertical, horizontal and DC predictions for one macroblock,
// with its own top-neighbour line buffer and left-neighbour column.
module intra16_mode_decision #(
  parameter int unsigned WIDTH   = 1280,
  parameter int unsigned LENGTH  = 720,
  parameter int unsigned MB_SIZE = 16
) (
  input logic                   clk,
  input logic                   reset,
  intra16_mode_decision_if.slave bus
);
  localparam int unsigned AW       = $clog2(WIDTH);
  localparam int unsigned NPix     = MB_SIZE * MB_SIZE;
  localparam logic [7:0]  LastLine = 8'(MB_SIZE - 1);
  localparam logic [7:0]  LastPix  = 8'(NPix - 1);
  // A frame only one macroblock tall never has a top neighbour.
  localparam bit          MultiRow = (LENGTH > MB_SIZE);

  typedef enum logic [2:0] {StIdle, StPrep, StAccum, StDecide, StUpdate, StDone} state_e;

  state_e        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [11:0]   sum_t_q, sum_t_d, sum_l_q, sum_l_d;
  logic [7:0]    dc_q, dc_d;
  logic [15:0]   sad_v_q, sad_v_d, sad_h_q, sad_h_d, sad_dc_q, sad_dc_d;
  logic [1:0]    mode_q, mode_d;
  logic [15:0]   bsad_q, bsad_d;

  logic [AW-1:0] col_q;
  logic          top_av_q, left_av_q;
  logic [7:0]    mb_q     [NPix];
  logic [7:0]    top_buf  [WIDTH];
  logic [7:0]    left_buf [MB_SIZE];

  logic [AW-1:0] top_idx;
  logic [7:0]    top_px, left_px, cur_px;

  function automatic logic [7:0] absdiff(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[8] ? 8'(-d) : d[7:0];
  endfunction

  assign top_idx = col_q + AW'(cnt_q[3:0]);
  assign top_px  = top_buf[top_idx];
  // PREP walks the left column by index i; ACCUM needs the row j of the current pixel.
  assign left_px = left_buf[(state_q == StAccum) ? cnt_q[7:4] : cnt_q[3:0]];
  assign cur_px  = mb_q[cnt_q];

  // Macroblock capture and neighbour storage survive reset.
  always_ff @(posedge clk) begin
    if (state_q == StIdle && bus.start) begin
      mb_q      <= bus.mb;
      col_q     <= bus.mbnumber[AW-1:0];
      top_av_q  <= MultiRow && (bus.mbnumber[31:16] != 16'd0);
      left_av_q <= (bus.mbnumber[15:0] != 16'd0);
    end
    if (state_q == StUpdate) begin
      top_buf[top_idx]      <= mb_q[{4'hF, cnt_q[3:0]}];
      left_buf[cnt_q[3:0]] <= mb_q[{cnt_q[3:0], 4'hF}];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      sum_t_q  <= '0;
      sum_l_q  <= '0;
      dc_q     <= '0;
      sad_v_q  <= '0;
      sad_h_q  <= '0;
      sad_dc_q <= '0;
      mode_q   <= 2'd2;
      bsad_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sum_t_q  <= sum_t_d;
      sum_l_q  <= sum_l_d;
      dc_q     <= dc_d;
      sad_v_q  <= sad_v_d;
      sad_h_q  <= sad_h_d;
      sad_dc_q <= sad_dc_d;
      mode_q   <= mode_d;
      bsad_q   <= bsad_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sum_t_d  = sum_t_q;
    sum_l_d  = sum_l_q;
    dc_d     = dc_q;
    sad_v_d  = sad_v_q;
    sad_h_d  = sad_h_q;
    sad_dc_d = sad_dc_q;
    mode_d   = mode_q;
    bsad_d   = bsad_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d  = StPrep;
          cnt_d    = '0;
          sum_t_d  = '0;
          sum_l_d  = '0;
          sad_v_d  = '0;
          sad_h_d  = '0;
          sad_dc_d = '0;
        end
      end
      StPrep: begin
        sum_t_d = sum_t_q + 12'(top_px);
        sum_l_d = sum_l_q + 12'(left_px);
        cnt_d   = cnt_q + 8'd1;
        if (cnt_q == LastLine) begin
          state_d = StAccum;
          cnt_d   = '0;
          if (top_av_q && left_av_q) dc_d = 8'((13'(sum_t_d) + 13'(sum_l_d) + 13'd16) >> 5);
          else if (top_av_q)         dc_d = 8'((sum_t_d + 12'd8) >> 4);
          else if (left_av_q)        dc_d = 8'((sum_l_d + 12'd8) >> 4);
          else                       dc_d = 8'd128;
        end
      end
      StAccum: begin
        sad_v_d  = sad_v_q + 16'(absdiff(cur_px, top_px));
        sad_h_d  = sad_h_q + 16'(absdiff(cur_px, left_px));
        sad_dc_d = sad_dc_q + 16'(absdiff(cur_px, dc_q));
        cnt_d    = cnt_q + 8'd1;
        if (cnt_q == LastPix) begin
          state_d = StDecide;
          cnt_d   = '0;
        end
      end
      StDecide: begin
        // Later candidates win ties, giving priority V > H > DC.
        mode_d = 2'd2;
        bsad_d = sad_dc_q;
        if (left_av_q && sad_h_q <= bsad_d) begin
          mode_d = 2'd1;
          bsad_d = sad_h_q;
        end
        if (top_av_q && sad_v_q <= bsad_d) begin
          mode_d = 2'd0;
          bsad_d = sad_v_q;
        end
        state_d = StUpdate;
      end
      StUpdate: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == LastLine) begin
          state_d = StDone;
          cnt_d   = '0;
        end
      end
      StDone: begin
        if (bus.ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.busy      = (state_q != StIdle);
  assign bus.valid     = (state_q == StDone);
  assign bus.best_mode = mode_q;
  assign bus.best_sad  = bsad_q;
endmodule

// File: tb/tb_intra16_mode_decision.sv
// Scoreboard bench for intra16_mode_decision on a 64x32 frame with a behavioural reference model.
module tb_intra16_mode_decision;
  localparam int unsigned W = 64;

  typedef struct {
    int mode;
    int sad;
  } res_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  intra16_mode_decision_if bus ();

  intra16_mode_decision #(
    .WIDTH  (W),
    .LENGTH (32),
    .MB_SIZE(16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int         n_vec = 0;
  int         n_err = 0;
  res_t       exp_q[$];
  logic [7:0] cur_mb [256];
  int         top_m [W];
  int         left_m [16];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic model(input int row, input int col, output int mode, output int sad);
    bit top_av, left_av;
    int st, sl, dc, sv, sh, sd, p;
    top_av  = (row != 0);
    left_av = (col != 0);
    st = 0;
    sl = 0;
    for (int i = 0; i < 16; i++) begin
      if (top_av)  st += top_m[col + i];
      if (left_av) sl += left_m[i];
    end
    if (top_av && left_av) dc = (st + sl + 16) >> 5;
    else if (top_av)       dc = (st + 8) >> 4;
    else if (left_av)      dc = (sl + 8) >> 4;
    else                   dc = 128;
    sv = 0;
    sh = 0;
    sd = 0;
    for (int j = 0; j < 16; j++) begin
      for (int k = 0; k < 16; k++) begin
        p = int'(cur_mb[j*16 + k]);
        sv += (p > top_m[col + k]) ? p - top_m[col + k] : top_m[col + k] - p;
        sh += (p > left_m[j]) ? p - left_m[j] : left_m[j] - p;
        sd += (p > dc) ? p - dc : dc - p;
      end
    end
    mode = 2;
    sad  = sd;
    if (left_av && sh <= sad) begin mode = 1; sad = sh; end
    if (top_av && sv <= sad)  begin mode = 0; sad = sv; end
  endtask

  task automatic fill_const(input int v);
    for (int i = 0; i < 256; i++) cur_mb[i] = 8'(v);
  endtask

  task automatic fill_random();
    int kind;
    int base [16];
    kind = $urandom_range(0, 2);
    for (int i = 0; i < 16; i++) base[i] = $urandom_range(0, 235);
    for (int j = 0; j < 16; j++)
      for (int k = 0; k < 16; k++)
        case (kind)
          0:       cur_mb[j*16 + k] = 8'($urandom_range(0, 255));
          1:       cur_mb[j*16 + k] = 8'(base[k] + $urandom_range(0, 20));
          default: cur_mb[j*16 + k] = 8'(base[j] + $urandom_range(0, 20));
        endcase
  endtask

  // Runs one macroblock end to end; use_exp selects a fixed expectation over the model.
  task automatic run_mb(input int row, input int col, input bit use_exp, input int emode,
                        input int esad, input bit spam, input int hold);
    res_t r, e_r;
    int   e;
    bit   busy_drop;
    if (use_exp) begin
      r.mode = emode;
      r.sad  = esad;
    end else begin
      model(row, col, r.mode, r.sad);
    end
    exp_q.push_back(r);
    bus.mbnumber = {16'(row), 16'(col)};
    bus.mb       = cur_mb;
    bus.start    = 1'b1;
    e = 0;
    busy_drop = 1'b0;
    do begin
      @(negedge clk);
      e++;
      bus.start = spam && ((e >= 2 && e <= 20) || e == 150);
      if (!bus.busy) busy_drop = 1'b1;
    end while (!bus.valid && e < 400);
    bus.start = 1'b0;
    check_eq("latency", e, 290);
    check_eq("busy_held", int'(busy_drop), 0);
    e_r = exp_q.pop_front();
    check_eq("best_mode", int'(bus.best_mode), e_r.mode);
    check_eq("best_sad", int'(bus.best_sad), e_r.sad);
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      check_eq("hold_valid", int'(bus.valid), 1);
      check_eq("hold_mode", int'(bus.best_mode), e_r.mode);
      check_eq("hold_sad", int'(bus.best_sad), e_r.sad);
    end
    bus.ack   = 1'b1;
    bus.start = spam;
    @(negedge clk);
    bus.ack   = 1'b0;
    bus.start = 1'b0;
    check_eq("valid_after_ack", int'(bus.valid), 0);
    check_eq("busy_after_ack", int'(bus.busy), 0);
    if (spam) begin
      repeat (5) @(negedge clk);
      check_eq("no_restart", int'(bus.busy), 0);
    end
    for (int i = 0; i < 16; i++) begin
      top_m[col + i] = int'(cur_mb[240 + i]);
      left_m[i]      = int'(cur_mb[i*16 + 15]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit seen_valid;
    bus.start    = 1'b0;
    bus.ack      = 1'b0;
    bus.mbnumber = '0;
    fill_const(0);
    bus.mb = cur_mb;
    for (int i = 0; i < W; i++) top_m[i] = 0;
    for (int i = 0; i < 16; i++) left_m[i] = 0;

    repeat (3) @(negedge clk);
    check_eq("rst_busy", int'(bus.busy), 0);
    check_eq("rst_valid", int'(bus.valid), 0);
    check_eq("rst_mode", int'(bus.best_mode), 2);
    check_eq("rst_sad", int'(bus.best_sad), 0);
    reset = 1'b1;
    @(negedge clk);

    // Nothing available: DC 128 against flat 100.
    fill_const(100);
    run_mb(0, 0, 1'b1, 2, 7168, 1'b0, 0);
    // Left only: H and DC both zero, H wins the tie.
    run_mb(0, 16, 1'b1, 1, 0, 1'b0, 0);

    // Row 0 of column ramps, then the same content below: V is exact.
    for (int j = 0; j < 16; j++)
      for (int k = 0; k < 16; k++) cur_mb[j*16 + k] = 8'(10 * k);
    for (int c = 0; c < W; c += 16) run_mb(0, c, 1'b0, 0, 0, 1'b0, 0);
    run_mb(16, 0, 1'b1, 0, 0, 1'b0, 0);

    // Spurious starts while busy, then a long-held result.
    fill_random();
    run_mb(16, 16, 1'b0, 0, 0, 1'b1, 20);

    // Reset in the middle of ACCUM.
    fill_random();
    bus.mbnumber = {16'd0, 16'd0};
    bus.mb       = cur_mb;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (100) @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("midrst_busy", int'(bus.busy), 0);
    check_eq("midrst_valid", int'(bus.valid), 0);
    check_eq("midrst_mode", int'(bus.best_mode), 2);
    check_eq("midrst_sad", int'(bus.best_sad), 0);
    @(negedge clk);
    reset = 1'b1;
    seen_valid = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (bus.valid) seen_valid = 1'b1;
    end
    check_eq("midrst_no_valid", int'(seen_valid), 0);
    fill_const(100);
    run_mb(0, 0, 1'b1, 2, 7168, 1'b0, 0);

    // Random raster pass over the whole 64x32 frame.
    for (int r = 0; r < 32; r += 16)
      for (int c = 0; c < W; c += 16) begin
        fill_random();
        run_mb(r, c, 1'b0, 0, 0, 1'b0, $urandom_range(0, 3));
      end

    check_eq("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/intra16_mode_decision.md
Name: intra16_mode_decision

Overview:
- Sits directly downstream of the macroblock extractor in IntraPred.
- Captures one 16x16 luma macroblock plus its position and forms the three Intra16x16 predictions: vertical (mode 0), horizontal (mode 1) and DC (mode 2).
- Accumulates the SAD of each prediction one pixel per cycle and reports the best mode and its SAD.
- Keeps the top-neighbour line buffer and the left-neighbour column itself, and updates them after each macroblock.

Parameters:
- WIDTH, 1280: frame width in pixels; depth of the top-neighbour line buffer.
- LENGTH, 720: frame height in pixels. Informational only.
- MB_SIZE, 16: macroblock edge in pixels. Fixed at 16; other values are unsupported.

Ports:
- clk  in  1: rising-edge clock.
- reset  in  1: asynchronous, active-low reset.
- start  in  1: request to process the current mb. Sampled only in IDLE.
- mbnumber  in  32: [31:16] pixel row, [15:0] pixel column of the top-left pixel. Both are multiples of 16 and in frame.
- mb  in  8 x 256: unpacked pixel array, index j*16+k (j = row, k = column). Must be stable in the start cycle.
- busy  out  1: high in every state except IDLE.
- valid  out  1: result available.
- ack  in  1: consumer accepts the result.
- best_mode  out  2: 0 vertical, 1 horizontal, 2 DC.
- best_sad  out  16: SAD of the chosen mode.

Behaviour:
- Reset (asynchronous, active-low): state=IDLE; busy=0, valid=0, best_mode=2, best_sad=0; all counters and accumulators cleared. Line buffer and left column are not cleared. Reset taken mid-operation abandons the macroblock and does not update the buffers.
- Availability:
  - top_av = (row != 0).
  - left_av = (col != 0).
  - The left column holds the right column of the previously processed macroblock. Macroblocks must arrive in raster order.
- FSM states: IDLE, PREP, ACCUM, DECIDE, UPDATE, DONE.
- IDLE: on start=1, latch mb, row, col, top_av and left_av on that edge, then go to PREP. start in any other state is ignored.
- PREP (16 cycles, i=0..15):
  - sumT += top[col+i]; sumL += left[i]. Both are 12-bit sums.
  - At exit, compute dc:
    - both available: (sumT+sumL+16)>>5
    - top only: (sumT+8)>>4
    - left only: (sumL+8)>>4
    - neither: 128
- ACCUM (256 cycles, raster p=j*16+k):
  - sadV += |mb[p]-top[col+k]|
  - sadH += |mb[p]-left[j]|
  - sadD += |mb[p]-dc|
  - Each |a-b| is computed on 9-bit signed differences. Accumulators are 16 bits; the maximum value 65280 cannot overflow.
- DECIDE (1 cycle):
  - Candidates: V only if top_av, H only if left_av, DC always.
  - Pick the minimum SAD. Ties resolve V > H > DC (lowest mode number wins).
  - Register best_mode and best_sad.
- UPDATE (16 cycles, i=0..15):
  - top[col+i] <= mb[240+i]
  - left[i] <= mb[i*16+15]
  - Neighbour reads for this macroblock are complete before any write.
- DONE:
  - valid=1; best_mode and best_sad are held stable.
  - On ack=1 go to IDLE at that edge; valid falls.
  - ack outside DONE is ignored.
  - A start in the same cycle as ack is ignored (the block is not yet in IDLE).
- Latency: valid rises on the 290th rising edge after the start-sampling edge (counting the start-sampling edge as edge 1): 1 + 16 + 256 + 1 + 16.
- busy rises on the start-sampling edge and falls on the ack edge.

Test Plan:
- Reset, then MB (0,0) all pixels 100, start:
  - expect valid after 290 edges, best_mode=2, best_sad=7168 (|100-128|*256).
  - busy high throughout.
- Next MB (0,16) all 100 (left available, top not):
  - H SAD 0, DC=(1600+8)>>4=100 so DC SAD 0.
  - Tie resolves to best_mode=1, best_sad=0.
- Fill row 0 with MBs whose column k pixels equal 10*k. Then MB (16,0) with the same content:
  - V SAD 0, DC (top only)=75, V wins.
  - Expect best_mode=0, best_sad=0.
- Pulse start repeatedly during PREP/ACCUM: ignored, exactly one result. Then hold ack low 20 cycles: valid and outputs stable; one-cycle ack returns the block to IDLE.
- Assert reset (low) mid-ACCUM:
  - outputs return to reset values immediately; no valid is produced.
  - A subsequent start at (0,0) yields the 7168/DC result again.
- Random MBs in raster order over a 64x32 frame (WIDTH=64): each best_mode and best_sad matches the reference model, including left/top edge availability.
